// File: rtl/ad7606_pkg.sv
// Shared types and constants for the AD7606 conversion sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: 3-bit FSM state encoding, OS[2:0] oversampling codes, a small max helper.
package ad7606_pkg;

    typedef enum logic [2:0] {
        ST_RST_ADC  = 3'd0,
        ST_IDLE     = 3'd1,
        ST_CONV     = 3'd2,
        ST_WAIT_BH  = 3'd3,
        ST_WAIT_BL  = 3'd4,
        ST_START_RD = 3'd5,
        ST_WAIT_RD  = 3'd6
    } state_t;

    // OS[2:0] oversampling ratio codes as the AD7606 decodes them
    localparam logic [2:0] OS_NONE = 3'd0;
    localparam logic [2:0] OS_2    = 3'd1;
    localparam logic [2:0] OS_4    = 3'd2;
    localparam logic [2:0] OS_8    = 3'd3;
    localparam logic [2:0] OS_16   = 3'd4;
    localparam logic [2:0] OS_32   = 3'd5;
    localparam logic [2:0] OS_64   = 3'd6;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ad7606_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous AD7606 BUSY into sys_clk_i.
// Latency: 2 sys_clk_i cycles from din change to dout.
// Backpressure: none, free-running.
// Ports: sys_clk_i clock, rst_i async active-high reset (clears to 0), din async input, dout synced output.
module ad7606_sync_2ff (
    input  logic sys_clk_i,
    input  logic rst_i,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/ad7606_conv_ctrl.sv
// Conversion sequencer for one AD7606 in parallel mode: power-up RESET, CONVST, BUSY tracking, read hand-off.
// Latency: request in cycle T drives convst_o low in T+1..T+CONVST_LOW; conv_done_o one cycle after read_done_i.
// Backpressure: requests arriving while a conversion is in flight are dropped and counted in overrun_cnt_o.
// Ports: enable_i/trig_i request conversions, soft_rst_i re-runs ADC reset, os_i/range_i latched in IDLE,
//        busy_i/read_done_i from ADC and read engine; ADC pins ad_reset_o/convst_o/os_o/range_o;
//        spi_start_o/conv_done_o/busy_o handshake; timeout_err_o/overrun_cnt_o status (cleared by clr_i).
module ad7606_conv_ctrl
    import ad7606_pkg::*;
#(
    parameter int SAMPLE_DIV = 5000,
    parameter int RST_CYCLES = 10,
    parameter int CONVST_LOW = 4,
    parameter int BUSY_TO    = 20000,
    parameter int RD_TO      = 64
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        trig_i,
    input  logic        soft_rst_i,
    input  logic [2:0]  os_i,
    input  logic        range_i,
    input  logic        clr_i,
    input  logic        busy_i,
    input  logic        read_done_i,
    output logic        ad_reset_o,
    output logic        convst_o,
    output logic [2:0]  os_o,
    output logic        range_o,
    output logic        spi_start_o,
    output logic        conv_done_o,
    output logic        busy_o,
    output logic        timeout_err_o,
    output logic [15:0] overrun_cnt_o
);

    localparam int TMR_W  = $clog2(SAMPLE_DIV) + 1;
    localparam int PH_MAX = max2(max2(RST_CYCLES, CONVST_LOW), max2(BUSY_TO, RD_TO));
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [PH_W-1:0]    ph;
    logic               busy_s;
    logic               tick;
    logic               req;
    logic               drop;
    logic               bh_to;
    logic               bl_to;
    logic               rd_to;
    logic               tmo;

    ad7606_sync_2ff u_busy_sync (
        .sys_clk_i (sys_clk_i),
        .rst_i     (rst_i),
        .din       (busy_i),
        .dout      (busy_s)
    );

    assign tick = enable_i && (timer == TMR_W'(SAMPLE_DIV - 1));
    assign req  = tick || trig_i;
    assign drop = req && (state != ST_IDLE);

    // A phase times out on its last allowed cycle unless the awaited event arrives in that same cycle.
    assign bh_to = (state == ST_WAIT_BH) && !busy_s      && (ph == PH_W'(BUSY_TO - 1));
    assign bl_to = (state == ST_WAIT_BL) &&  busy_s      && (ph == PH_W'(BUSY_TO - 1));
    assign rd_to = (state == ST_WAIT_RD) && !read_done_i && (ph == PH_W'(RD_TO - 1));
    assign tmo   = bh_to || bl_to || rd_to;

    // Sample-rate timer, parked at zero while auto conversions are disabled.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            timer <= '0;
        end else if (!enable_i || tick) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_RST_ADC;
            ph          <= '0;
            ad_reset_o  <= 1'b1;
            convst_o    <= 1'b1;
            os_o        <= '0;
            range_o     <= 1'b0;
            spi_start_o <= 1'b0;
            conv_done_o <= 1'b0;
            busy_o      <= 1'b1;
        end else begin
            spi_start_o <= 1'b0;
            conv_done_o <= 1'b0;
            if (soft_rst_i || tmo) begin
                // Either path fully re-resets the ADC; CONVST parked high, no read started.
                state      <= ST_RST_ADC;
                ph         <= '0;
                ad_reset_o <= 1'b1;
                convst_o   <= 1'b1;
                busy_o     <= 1'b1;
            end else begin
                case (state)
                    ST_RST_ADC: begin
                        // ph 0..RST_CYCLES-1 with RESET high, then one low cycle before IDLE.
                        if (ph == PH_W'(RST_CYCLES)) begin
                            state  <= ST_IDLE;
                            ph     <= '0;
                            busy_o <= 1'b0;
                        end else begin
                            if (ph == PH_W'(RST_CYCLES - 1)) begin
                                ad_reset_o <= 1'b0;
                            end
                            ph <= ph + 1'b1;
                        end
                    end
                    ST_IDLE: begin
                        os_o    <= os_i;
                        range_o <= range_i;
                        if (req) begin
                            state    <= ST_CONV;
                            ph       <= '0;
                            convst_o <= 1'b0;
                            busy_o   <= 1'b1;
                        end
                    end
                    ST_CONV: begin
                        if (ph == PH_W'(CONVST_LOW - 1)) begin
                            state    <= ST_WAIT_BH;
                            ph       <= '0;
                            convst_o <= 1'b1;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                    ST_WAIT_BH: begin
                        if (busy_s) begin
                            state <= ST_WAIT_BL;
                            ph    <= '0;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                    ST_WAIT_BL: begin
                        if (!busy_s) begin
                            state       <= ST_START_RD;
                            ph          <= '0;
                            spi_start_o <= 1'b1;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                    ST_START_RD: begin
                        state <= ST_WAIT_RD;
                        ph    <= '0;
                    end
                    ST_WAIT_RD: begin
                        if (read_done_i) begin
                            state       <= ST_IDLE;
                            ph          <= '0;
                            conv_done_o <= 1'b1;
                            busy_o      <= 1'b0;
                        end else begin
                            ph <= ph + 1'b1;
                        end
                    end
                    default: begin
                        state      <= ST_RST_ADC;
                        ph         <= '0;
                        ad_reset_o <= 1'b1;
                        convst_o   <= 1'b1;
                        busy_o     <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Host status; a clear in the same cycle as a new event takes priority.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            timeout_err_o <= 1'b0;
            overrun_cnt_o <= '0;
        end else if (clr_i) begin
            timeout_err_o <= 1'b0;
            overrun_cnt_o <= '0;
        end else begin
            if (tmo) begin
                timeout_err_o <= 1'b1;
            end
            if (drop && (overrun_cnt_o != 16'hFFFF)) begin
                overrun_cnt_o <= overrun_cnt_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_ad7606_conv_ctrl.sv
// Directed bench for ad7606_conv_ctrl with a behavioural BUSY / read-engine model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_ad7606_conv_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        trig_i = 1'b0;
    logic        soft_rst_i = 1'b0;
    logic [2:0]  os_i = 3'd0;
    logic        range_i = 1'b0;
    logic        clr_i = 1'b0;
    logic        busy_i;
    logic        read_done_i;
    logic        ad_reset_o;
    logic        convst_o;
    logic [2:0]  os_o;
    logic        range_o;
    logic        spi_start_o;
    logic        conv_done_o;
    logic        busy_o;
    logic        timeout_err_o;
    logic [15:0] overrun_cnt_o;

    always #5 sys_clk = ~sys_clk;

    ad7606_conv_ctrl #(
        .SAMPLE_DIV (100),
        .RST_CYCLES (10),
        .CONVST_LOW (4),
        .BUSY_TO    (200),
        .RD_TO      (64)
    ) dut (
        .sys_clk_i     (sys_clk),
        .rst_i         (rst_i),
        .enable_i      (enable_i),
        .trig_i        (trig_i),
        .soft_rst_i    (soft_rst_i),
        .os_i          (os_i),
        .range_i       (range_i),
        .clr_i         (clr_i),
        .busy_i        (busy_i),
        .read_done_i   (read_done_i),
        .ad_reset_o    (ad_reset_o),
        .convst_o      (convst_o),
        .os_o          (os_o),
        .range_o       (range_o),
        .spi_start_o   (spi_start_o),
        .conv_done_o   (conv_done_o),
        .busy_o        (busy_o),
        .timeout_err_o (timeout_err_o),
        .overrun_cnt_o (overrun_cnt_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ADC / read-engine model state (sampled and driven on the falling edge)
    bit bm_en = 1'b1;
    bit rd_en = 1'b1;
    int cyc_n = 0, n_fall = 0, n_spi = 0, n_done = 0;
    int last_fall = 0, period = 0, low_cnt = 0, low_len = 0;
    int b_delay = 0, b_hold = 0, r_delay = 0, rd_cyc = 0, rd2done = 0;
    logic prev_cv = 1'b1;

    initial begin
        busy_i      = 1'b0;
        read_done_i = 1'b0;
        forever begin
            @(negedge sys_clk);
            cyc_n++;
            if (convst_o === 1'b0) low_cnt++;
            if (prev_cv === 1'b1 && convst_o === 1'b0) begin
                n_fall++;
                period    = cyc_n - last_fall;
                last_fall = cyc_n;
            end
            // BUSY rises 2 cycles after CONVST rises and stays high 40 cycles
            if (prev_cv === 1'b0 && convst_o === 1'b1) begin
                low_len = low_cnt;
                low_cnt = 0;
                if (bm_en) b_delay = 2;
            end else if (b_delay > 0) begin
                b_delay--;
                if (b_delay == 0) begin
                    busy_i = 1'b1;
                    b_hold = 40;
                end
            end else if (b_hold > 0) begin
                b_hold--;
                if (b_hold == 0) busy_i = 1'b0;
            end
            prev_cv = convst_o;
            // read engine answers 20 cycles after its start pulse with a one-cycle data_flag
            if (read_done_i) begin
                read_done_i = 1'b0;
            end else if (r_delay > 0) begin
                r_delay--;
                if (r_delay == 0) begin
                    read_done_i = 1'b1;
                    rd_cyc      = cyc_n;
                end
            end
            if (spi_start_o === 1'b1) begin
                n_spi++;
                if (rd_en) r_delay = 20;
            end
            if (conv_done_o === 1'b1) begin
                n_done++;
                rd2done = cyc_n - rd_cyc;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_trig();
        trig_i = 1'b1;
        @(negedge sys_clk);
        trig_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(negedge sys_clk);
        clr_i = 1'b0;
    endtask

    task automatic clear_stats();
        n_fall = 0; n_spi = 0; n_done = 0;
    endtask

    initial begin
        int n;
        int hi;

        // ---- 1: reset values, ADC reset sequence, auto conversions
        cyc(2);
        chk("rst_ad_reset", ad_reset_o, 1);
        chk("rst_convst", convst_o, 1);
        chk("rst_busy", busy_o, 1);
        chk("rst_os_range", {os_o, range_o}, 0);
        chk("rst_spi_done", {spi_start_o, conv_done_o}, 0);
        chk("rst_status", {timeout_err_o, overrun_cnt_o}, 0);
        rst_i = 1'b0;
        cyc(9);
        chk("adrst_last_high", ad_reset_o, 1);
        cyc(1);
        chk("adrst_low_cycle", {ad_reset_o, busy_o}, 2'b01);
        cyc(1);
        chk("idle_busy_low", busy_o, 0);

        clear_stats();
        enable_i = 1'b1;
        cyc(350);
        enable_i = 1'b0;
        cyc(100);
        chk("auto_convst_cnt", n_fall, 3);
        chk("auto_period", period, 100);
        chk("auto_low_width", low_len, 4);
        chk("auto_spi_cycles", n_spi, 3);
        chk("auto_done_cnt", n_done, 3);
        chk("auto_rd_to_done", rd2done, 1);
        chk("auto_overrun", overrun_cnt_o, 0);

        // ---- 2: trig_i coincident with tick, plus request latency
        clear_stats();
        enable_i = 1'b1;
        cyc(99);
        trig_i = 1'b1;
        cyc(1);
        trig_i   = 1'b0;
        enable_i = 1'b0;
        chk("lat_convst_t1", convst_o, 0);
        cyc(3);
        chk("lat_convst_t4", convst_o, 0);
        cyc(1);
        chk("lat_convst_t5", convst_o, 1);
        cyc(100);
        chk("coinc_convst_cnt", n_fall, 1);
        chk("coinc_overrun", overrun_cnt_o, 0);

        // ---- 3: dropped triggers, clear, clear priority, saturation
        clear_stats();
        for (int k = 0; k < 7; k++) begin
            pulse_trig();
            cyc(9);
        end
        cyc(100);
        chk("ovr_convst_cnt", n_fall, 1);
        chk("ovr_count", overrun_cnt_o, 6);
        pulse_clr();
        chk("ovr_clr", overrun_cnt_o, 0);
        pulse_trig();
        cyc(10);
        trig_i = 1'b1;
        clr_i  = 1'b1;
        cyc(1);
        trig_i = 1'b0;
        clr_i  = 1'b0;
        chk("ovr_clr_wins", overrun_cnt_o, 0);
        cyc(100);
        trig_i = 1'b1;
        cyc(67000);
        chk("ovr_saturate", overrun_cnt_o, 16'hFFFF);
        cyc(200);
        chk("ovr_sat_hold", overrun_cnt_o, 16'hFFFF);
        trig_i = 1'b0;
        cyc(100);
        pulse_clr();

        // ---- 4: BUSY never rises -> timeout and full ADC re-reset
        clear_stats();
        bm_en = 1'b0;
        pulse_trig();
        n = 0;
        while (convst_o !== 1'b1 && n < 20) begin cyc(1); n++; end
        chk("bh_convst_rise", convst_o, 1);
        n = 0;
        while (timeout_err_o !== 1'b1 && n < 400) begin cyc(1); n++; end
        chk("bh_timeout_cycles", n, 200);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (ad_reset_o === 1'b1) hi++;
            cyc(1);
        end
        chk("bh_adreset_width", hi, 10);
        chk("bh_no_spi", n_spi, 0);
        chk("bh_back_idle", busy_o, 0);
        pulse_clr();
        chk("bh_clr", timeout_err_o, 0);

        // read_done withheld -> read timeout
        bm_en = 1'b1;
        rd_en = 1'b0;
        clear_stats();
        pulse_trig();
        n = 0;
        while (spi_start_o !== 1'b1 && n < 200) begin cyc(1); n++; end
        chk("rd_spi_seen", spi_start_o, 1);
        cyc(1);
        n = 0;
        while (timeout_err_o !== 1'b1 && n < 200) begin cyc(1); n++; end
        chk("rd_timeout_cycles", n, 64);
        chk("rd_adreset", ad_reset_o, 1);
        cyc(30);
        chk("rd_no_done", n_done, 0);
        pulse_clr();
        rd_en = 1'b1;

        // ---- 5: os/range change mid-conversion, soft reset in WAIT_RD
        os_i    = 3'd3;
        range_i = 1'b0;
        cyc(2);
        chk("os_idle_latch", os_o, 3);
        pulse_trig();
        cyc(19);
        os_i    = 3'd5;
        range_i = 1'b1;
        cyc(10);
        chk("os_hold_wait_bl", {os_o, range_o}, {3'd3, 1'b0});
        n = 0;
        while (conv_done_o !== 1'b1 && n < 200) begin cyc(1); n++; end
        chk("os_done_seen", conv_done_o, 1);
        chk("os_hold_at_done", os_o, 3);
        cyc(1);
        chk("os_new_in_idle", {os_o, range_o}, {3'd5, 1'b1});

        clear_stats();
        pulse_trig();
        cyc(19);
        pulse_trig();
        chk("srst_pre_overrun", overrun_cnt_o, 1);
        n = 0;
        while (spi_start_o !== 1'b1 && n < 200) begin cyc(1); n++; end
        chk("srst_spi_seen", spi_start_o, 1);
        cyc(5);
        soft_rst_i = 1'b1;
        cyc(1);
        soft_rst_i = 1'b0;
        chk("srst_outputs", {ad_reset_o, convst_o, busy_o, spi_start_o}, 4'b1110);
        cyc(40);
        chk("srst_no_done", n_done, 0);
        chk("srst_counters_kept", {timeout_err_o, overrun_cnt_o}, 17'd1);
        chk("srst_back_idle", busy_o, 0);

        // ---- 6: async reset during CONV
        bm_en = 1'b0;
        pulse_trig();
        cyc(1);
        chk("arst_in_conv", convst_o, 0);
        rst_i = 1'b1;
        #1;
        chk("arst_immediate", {convst_o, ad_reset_o, busy_o}, 3'b111);
        cyc(5);
        rst_i = 1'b0;
        cyc(1);
        chk("arst_overrun", overrun_cnt_o, 0);
        chk("arst_os", os_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
